// File: rtl/adder_4bit.sv
// 4-bit ripple-carry adder with carry-in/carry-out on individual bit ports.
// REG_OUT selects a combinational result or one registered on posedge clk.
module adder_4bit #(
    parameter int unsigned REG_OUT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic a_0_,
    input  logic a_1_,
    input  logic a_2_,
    input  logic a_3_,
    input  logic b_0_,
    input  logic b_1_,
    input  logic b_2_,
    input  logic b_3_,
    input  logic cin,
    output logic cout,
    output logic sum_0_,
    output logic sum_1_,
    output logic sum_2_,
    output logic sum_3_
);

    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic [4:0] c;
    logic [4:0] res;
    logic [4:0] res_out;

    assign a = {a_3_, a_2_, a_1_, a_0_};
    assign b = {b_3_, b_2_, b_1_, b_0_};

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign res = {c[4], s};

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [4:0] res_q;
            logic [4:0] res_d;

            always_comb begin
                res_d = res;
            end

            // Asynchronous clear forces the outputs low without waiting for a clock.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    res_q <= '0;
                end else begin
                    res_q <= res_d;
                end
            end

            assign res_out = res_q;
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
            assign res_out        = res;
        end
    endgenerate

    assign {cout, sum_3_, sum_2_, sum_1_, sum_0_} = res_out;

endmodule

// File: tb/tb_adder_4bit.sv
// Self-checking bench: a combinational and a registered adder_4bit share stimulus and
// are compared against a plain-arithmetic A+B+cin model.
module tb_adder_4bit;

    logic       clk;
    logic       reset;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;

    logic       c_cout, c_s0, c_s1, c_s2, c_s3;
    logic       r_cout, r_s0, r_s1, r_s2, r_s3;
    logic [4:0] comb_out;
    logic [4:0] reg_out;

    int unsigned vectors;
    int unsigned miscompares;

    assign comb_out = {c_cout, c_s3, c_s2, c_s1, c_s0};
    assign reg_out  = {r_cout, r_s3, r_s2, r_s1, r_s0};

    adder_4bit #(.REG_OUT(0)) u_comb (
        .clk    (clk),
        .reset  (reset),
        .a_0_   (a[0]),
        .a_1_   (a[1]),
        .a_2_   (a[2]),
        .a_3_   (a[3]),
        .b_0_   (b[0]),
        .b_1_   (b[1]),
        .b_2_   (b[2]),
        .b_3_   (b[3]),
        .cin    (cin),
        .cout   (c_cout),
        .sum_0_ (c_s0),
        .sum_1_ (c_s1),
        .sum_2_ (c_s2),
        .sum_3_ (c_s3)
    );

    adder_4bit #(.REG_OUT(1)) u_reg (
        .clk    (clk),
        .reset  (reset),
        .a_0_   (a[0]),
        .a_1_   (a[1]),
        .a_2_   (a[2]),
        .a_3_   (a[3]),
        .b_0_   (b[0]),
        .b_1_   (b[1]),
        .b_2_   (b[2]),
        .b_3_   (b[3]),
        .cin    (cin),
        .cout   (r_cout),
        .sum_0_ (r_s0),
        .sum_1_ (r_s1),
        .sum_2_ (r_s2),
        .sum_3_ (r_s3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] model(input int unsigned x, input int unsigned y,
                                         input int unsigned ci);
        int unsigned total;
        total = x + y + ci;
        return total[4:0];
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s a=%0d b=%0d cin=%0d observed=%b expected=%b",
                   tag, a, b, cin, obs, exp);
        end
    endtask

    // Drive on negedge, check both instances on the following negedge.
    task automatic apply(input string tag, input logic [3:0] x, input logic [3:0] y,
                         input logic ci);
        logic [4:0] exp;
        @(negedge clk);
        a   = x;
        b   = y;
        cin = ci;
        exp = model(int'(x), int'(y), int'(ci));
        #1;
        check({tag, "_comb0"}, comb_out, exp);
        @(negedge clk);
        check({tag, "_comb"}, comb_out, exp);
        check({tag, "_reg"}, reg_out, exp);
    endtask

    initial begin
        logic [3:0] da [5];
        logic [3:0] db [5];
        logic       dc [5];

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        a           = 4'd9;
        b           = 4'd6;
        cin         = 1'b1;

        // Reset state; the combinational instance ignores reset.
        #1;
        check("reset_reg", reg_out, 5'd0);
        check("reset_comb", comb_out, 5'd16);
        @(posedge clk);
        #1;
        check("reset_hold_reg", reg_out, 5'd0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_release_before_edge", reg_out, 5'd0);

        da = '{4'd0, 4'd15, 4'd15, 4'd5, 4'd5};
        db = '{4'd0, 4'd1, 4'd15, 4'd10, 4'd10};
        dc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            apply($sformatf("directed%0d", i), da[i], db[i], dc[i]);
        end

        for (int v = 0; v < 512; v++) begin
            logic [8:0] vec;
            vec = 9'(v);
            apply("sweep", vec[8:5], vec[4:1], vec[0]);
        end

        for (int k = 0; k < 64; k++) begin
            apply("random", 4'($urandom_range(15)), 4'($urandom_range(15)),
                  1'($urandom_range(1)));
        end

        // Leave a nonzero registered result, then assert reset between edges.
        apply("prereset", 4'd12, 4'd9, 1'b1);
        @(posedge clk);
        #2;
        a     = 4'd3;
        b     = 4'd4;
        cin   = 1'b0;
        reset = 1'b1;
        #1;
        check("async_reset_reg", reg_out, 5'd0);
        check("async_reset_comb", comb_out, 5'd7);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_release_no_edge", reg_out, 5'd0);
        @(posedge clk);
        #1;
        check("post_release_first_edge", reg_out, 5'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
